// File: rtl/campfire_pkg.sv
// -----------------------------------------------------------------------------
// campfire_pkg
// Shared types and helpers for the campfire checkpoint controller.
//   - state_t    : checkpoint sequencer states
//   - X_*/Y_*    : bit positions of the coordinate fields in the packed
//                  32-bit state word {x[31:22], y[21:12], unused[11:0]}
//   - COORD_W    : width of one coordinate field
//   - get_x/get_y/pack_state : field access for the packed state word
// -----------------------------------------------------------------------------
package campfire_pkg;

   typedef enum logic [1:0] {
      ST_UNLIT    = 2'd0,
      ST_LIGHTING = 2'd1,
      ST_LIT      = 2'd2,
      ST_RESPAWN  = 2'd3
   } state_t;

   localparam int unsigned X_MSB   = 31;
   localparam int unsigned X_LSB   = 22;
   localparam int unsigned Y_MSB   = 21;
   localparam int unsigned Y_LSB   = 12;
   localparam int unsigned COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   function automatic coord_t get_x(input logic [31:0] word);
      return word[X_MSB:X_LSB];
   endfunction

   function automatic coord_t get_y(input logic [31:0] word);
      return word[Y_MSB:Y_LSB];
   endfunction

   // Low 12 bits of a packed state word are always written as zero.
   function automatic logic [31:0] pack_state(input coord_t x, input coord_t y);
      return {x, y, 12'b0};
   endfunction

endpackage

// File: rtl/campfire_overlap.sv
// -----------------------------------------------------------------------------
// campfire_overlap
// Combinational box-overlap test between the player and the campfire.
// Overlap when |px-cx| < HIT_W and |py-cy| < HIT_H. Differences are formed
// at COORD_W+1 bits signed, so no wrap-around occurs at the screen edges.
//
// Ports:
//   campfire_word  in  32  packed campfire position
//   player_word    in  32  packed player position
//   overlap        out 1   player box touches campfire box
// -----------------------------------------------------------------------------
module campfire_overlap
   import campfire_pkg::*;
#(
   parameter int unsigned HIT_W = 16,
   parameter int unsigned HIT_H = 16
) (
   input  logic [31:0] campfire_word,
   input  logic [31:0] player_word,
   output logic        overlap
);

   localparam logic [COORD_W:0] HIT_W_C = (COORD_W+1)'(HIT_W);
   localparam logic [COORD_W:0] HIT_H_C = (COORD_W+1)'(HIT_H);

   logic signed [COORD_W:0] dx;
   logic signed [COORD_W:0] dy;
   logic        [COORD_W:0] abs_dx;
   logic        [COORD_W:0] abs_dy;
   logic                    unused_bits;

   // Low 12 bits of the state words carry no position information.
   assign unused_bits = ^{campfire_word[11:0], player_word[11:0]};

   always_comb begin
      dx     = $signed({1'b0, get_x(player_word)}) - $signed({1'b0, get_x(campfire_word)});
      dy     = $signed({1'b0, get_y(player_word)}) - $signed({1'b0, get_y(campfire_word)});
      abs_dx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
      abs_dy = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
      overlap = (abs_dx < HIT_W_C) && (abs_dy < HIT_H_C);
   end

endmodule

// File: rtl/campfire_checkpoint_ctrl.sv
// -----------------------------------------------------------------------------
// campfire_checkpoint_ctrl
// Campfire checkpoint sequencer: detects player contact, runs the lighting
// sequence, issues heal pulses, and on player death runs the respawn delay
// while presenting the respawn position.
//
// Optional build macro: CAMPFIRE_HEAL_COOLDOWN_EN
//   When defined, LIT entry-edge heals are suppressed for COOLDOWN_FRAMES
//   ticks after any heal pulse. When undefined, every entry edge heals.
//
// Ports:
//   sim_clk        in  1   system clock
//   reset          in  1   asynchronous active-low reset
//   frame_tick     in  1   one-cycle strobe per video frame
//   campfireState  in  32  packed campfire position
//   playerState    in  32  packed player position
//   player_dead    in  1   one-cycle death pulse
//   lit            out 1   fire burning (LIGHTING/LIT, or RESPAWN with checkpoint)
//   heal_pulse     out 1   one-cycle heal request
//   respawn_req    out 1   high for the whole RESPAWN state
//   respawnState   out 32  packed respawn position
//   flame_frame    out 2   flame sprite index
//   busy           out 1   high in LIGHTING or RESPAWN
// -----------------------------------------------------------------------------
module campfire_checkpoint_ctrl
   import campfire_pkg::*;
#(
   parameter int unsigned HIT_W           = 16,
   parameter int unsigned HIT_H           = 16,
   parameter int unsigned LIGHT_FRAMES    = 30,
   parameter int unsigned RESPAWN_FRAMES  = 60,
   parameter int unsigned ANIM_DIV        = 8,
   parameter logic [31:0] DEFAULT_SPAWN   = 32'h0C81_4000
`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
   ,
   parameter int unsigned COOLDOWN_FRAMES = 120
`endif
) (
   input  logic        sim_clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [31:0] campfireState,
   input  logic [31:0] playerState,
   input  logic        player_dead,
   output logic        lit,
   output logic        heal_pulse,
   output logic        respawn_req,
   output logic [31:0] respawnState,
   output logic [1:0]  flame_frame,
   output logic        busy
);

   localparam logic [15:0] LIGHT_LOAD   = 16'(LIGHT_FRAMES - 1);
   localparam logic [15:0] RESPAWN_LOAD = 16'(RESPAWN_FRAMES - 1);
   localparam logic [7:0]  ANIM_LAST    = 8'(ANIM_DIV - 1);

   state_t      state;
   logic [15:0] cnt;
   logic        has_checkpoint;
   logic [31:0] checkpoint;
   logic        overlap;
   logic        overlap_q;
   logic        heal_ok;
   logic        anim_active;
   logic [7:0]  anim_cnt;

   campfire_overlap #(
      .HIT_W (HIT_W),
      .HIT_H (HIT_H)
   ) u_overlap (
      .campfire_word (campfireState),
      .player_word   (playerState),
      .overlap       (overlap)
   );

`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
   localparam logic [15:0] COOL_LOAD = 16'(COOLDOWN_FRAMES);
   logic [15:0] cooldown;
   assign heal_ok = (cooldown == '0);
`else
   assign heal_ok = 1'b1;
`endif

   assign anim_active = (state == ST_LIGHTING) || (state == ST_LIT) ||
                        ((state == ST_RESPAWN) && has_checkpoint);

   // Sequencer. lit/busy/respawn_req are registered and written on every
   // transition so they always reflect the state being entered.
   always_ff @(posedge sim_clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_UNLIT;
         cnt            <= '0;
         has_checkpoint <= 1'b0;
         checkpoint     <= '0;
         overlap_q      <= 1'b0;
         lit            <= 1'b0;
         heal_pulse     <= 1'b0;
         respawn_req    <= 1'b0;
         busy           <= 1'b0;
         respawnState   <= DEFAULT_SPAWN;
`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
         cooldown       <= '0;
`endif
      end else begin
         heal_pulse <= 1'b0;
         if (frame_tick) begin
            overlap_q <= overlap;
         end
`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
         if (frame_tick && (cooldown != '0)) begin
            cooldown <= cooldown - 1'b1;
         end
`endif
         // Death wins over any overlap tick; it is ignored while respawning.
         if ((state != ST_RESPAWN) && player_dead) begin
            state        <= ST_RESPAWN;
            cnt          <= RESPAWN_LOAD;
            respawn_req  <= 1'b1;
            busy         <= 1'b1;
            lit          <= has_checkpoint;
            respawnState <= has_checkpoint ? checkpoint : DEFAULT_SPAWN;
         end else begin
            case (state)
               ST_UNLIT: begin
                  if (frame_tick && overlap) begin
                     state          <= ST_LIGHTING;
                     cnt            <= LIGHT_LOAD;
                     checkpoint     <= pack_state(get_x(campfireState), get_y(campfireState));
                     has_checkpoint <= 1'b1;
                     lit            <= 1'b1;
                     busy           <= 1'b1;
                  end
               end
               ST_LIGHTING: begin
                  if (frame_tick) begin
                     if (cnt == '0) begin
                        state      <= ST_LIT;
                        busy       <= 1'b0;
                        heal_pulse <= 1'b1;
`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
                        cooldown   <= COOL_LOAD;
`endif
                     end else begin
                        cnt <= cnt - 1'b1;
                     end
                  end
               end
               ST_LIT: begin
                  // Heal only on the tick the player steps onto the fire.
                  if (frame_tick && overlap && !overlap_q && heal_ok) begin
                     heal_pulse <= 1'b1;
`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
                     cooldown   <= COOL_LOAD;
`endif
                  end
               end
               ST_RESPAWN: begin
                  if (frame_tick) begin
                     if (cnt == '0) begin
                        state       <= has_checkpoint ? ST_LIT : ST_UNLIT;
                        respawn_req <= 1'b0;
                        busy        <= 1'b0;
                        lit         <= has_checkpoint;
                        // Forget contact history so the first touch after
                        // respawn counts as a fresh entry.
                        overlap_q   <= 1'b0;
`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
                        cooldown    <= '0;
`endif
                     end else begin
                        cnt <= cnt - 1'b1;
                     end
                  end
               end
               default: begin
                  state <= ST_UNLIT;
               end
            endcase
         end
      end
   end

   // Flame animation. The only way into LIGHTING is from UNLIT, where the
   // divider is held clear, so each lighting sequence starts from step 0.
   always_ff @(posedge sim_clk or negedge reset) begin
      if (!reset) begin
         anim_cnt    <= '0;
         flame_frame <= '0;
      end else if (!anim_active) begin
         anim_cnt    <= '0;
         flame_frame <= '0;
      end else if (frame_tick) begin
         if (anim_cnt == ANIM_LAST) begin
            anim_cnt    <= '0;
            flame_frame <= flame_frame + 2'd1;
         end else begin
            anim_cnt <= anim_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_campfire_checkpoint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_campfire_checkpoint_ctrl
// Directed self-checking bench for campfire_checkpoint_ctrl.
// Status vector st = {lit, busy, respawn_req, heal_pulse, flame_frame}.
// -----------------------------------------------------------------------------
module tb_campfire_checkpoint_ctrl;

   localparam logic [31:0] DEF_SPAWN = 32'h0C81_4000;
   localparam logic [31:0] CAMP      = {10'd250, 10'd180, 12'd0};   // 32'h3E8B4000
   localparam logic [31:0] CAMP_MOVE = {10'd100, 10'd100, 12'd0};
   localparam logic [31:0] FAR       = {10'd700, 10'd500, 12'd0};
   localparam logic [31:0] AWAY      = {10'd300, 10'd180, 12'd0};
`ifdef CAMPFIRE_HEAL_COOLDOWN_EN
   localparam int REENTRY_HEAL = 0;
`else
   localparam int REENTRY_HEAL = 1;
`endif

   logic        sim_clk;
   logic        reset;
   logic        frame_tick;
   logic [31:0] campfireState;
   logic [31:0] playerState;
   logic        player_dead;
   logic        lit;
   logic        heal_pulse;
   logic        respawn_req;
   logic [31:0] respawnState;
   logic [1:0]  flame_frame;
   logic        busy;
   logic [5:0]  st;

   int checks;
   int failures;
   int heal_count;
   int h0;

   campfire_checkpoint_ctrl dut (
      .sim_clk       (sim_clk),
      .reset         (reset),
      .frame_tick    (frame_tick),
      .campfireState (campfireState),
      .playerState   (playerState),
      .player_dead   (player_dead),
      .lit           (lit),
      .heal_pulse    (heal_pulse),
      .respawn_req   (respawn_req),
      .respawnState  (respawnState),
      .flame_frame   (flame_frame),
      .busy          (busy)
   );

   assign st = {lit, busy, respawn_req, heal_pulse, flame_frame};

   initial sim_clk = 1'b0;
   always #5 sim_clk = ~sim_clk;

   // Count heal pulses one time unit after each active edge.
   always begin
      @(posedge sim_clk);
      #1;
      if (heal_pulse === 1'b1) heal_count++;
   end

   task automatic do_tick();
      @(negedge sim_clk);
      frame_tick = 1'b1;
      @(negedge sim_clk);
      frame_tick = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic pulse_death();
      @(negedge sim_clk);
      player_dead = 1'b1;
      @(negedge sim_clk);
      player_dead = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sim_clk);
      checks++;
      if (st !== 6'b000000) begin
         failures++; $display("FAIL reset_status got=%b want=%b", st, 6'b000000);
      end
      checks++;
      if (respawnState !== DEF_SPAWN) begin
         failures++; $display("FAIL reset_respawn got=%h want=%h", respawnState, DEF_SPAWN);
      end
      reset = 1'b1;
   endtask

   task automatic test_death_unlit();
      playerState = FAR;
      pulse_death();
      checks++;
      if (st !== 6'b011000) begin
         failures++; $display("FAIL death_unlit_enter got=%b want=%b", st, 6'b011000);
      end
      checks++;
      if (respawnState !== DEF_SPAWN) begin
         failures++; $display("FAIL death_unlit_pos got=%h want=%h", respawnState, DEF_SPAWN);
      end
      tick_n(59);
      checks++;
      if (st !== 6'b011000) begin
         failures++; $display("FAIL death_unlit_hold got=%b want=%b", st, 6'b011000);
      end
      do_tick();
      checks++;
      if (st !== 6'b000000) begin
         failures++; $display("FAIL death_unlit_exit got=%b want=%b", st, 6'b000000);
      end
   endtask

   task automatic test_overlap_boundary();
      logic [31:0] miss [4];
      miss[0] = {10'd266, 10'd180, 12'd0};
      miss[1] = {10'd234, 10'd180, 12'd0};
      miss[2] = {10'd250, 10'd196, 12'd0};
      miss[3] = {10'd250, 10'd164, 12'd0};
      for (int i = 0; i < 4; i++) begin
         playerState = miss[i];
         do_tick();
         checks++;
         if (st !== 6'b000000) begin
            failures++; $display("FAIL overlap_edge_%0d got=%b want=%b", i, st, 6'b000000);
         end
      end
      playerState = {10'd265, 10'd180, 12'd0};
      do_tick();
      checks++;
      if (st !== 6'b110000) begin
         failures++; $display("FAIL overlap_inside got=%b want=%b", st, 6'b110000);
      end
   endtask

   task automatic test_lighting();
      h0 = heal_count;
      tick_n(29);
      checks++;
      if (st !== 6'b110011) begin
         failures++; $display("FAIL lighting_29 got=%b want=%b", st, 6'b110011);
      end
      do_tick();
      checks++;
      if (st !== 6'b100111) begin
         failures++; $display("FAIL lighting_done got=%b want=%b", st, 6'b100111);
      end
      @(negedge sim_clk);
      checks++;
      if (st !== 6'b100011) begin
         failures++; $display("FAIL heal_width got=%b want=%b", st, 6'b100011);
      end
      tick_n(2);
      checks++;
      if (st !== 6'b100000) begin
         failures++; $display("FAIL flame_wrap got=%b want=%b", st, 6'b100000);
      end
      tick_n(8);
      checks++;
      if (st !== 6'b100001) begin
         failures++; $display("FAIL flame_step got=%b want=%b", st, 6'b100001);
      end
      checks++;
      if (heal_count !== h0 + 1) begin
         failures++; $display("FAIL lighting_heals got=%0d want=%0d", heal_count - h0, 1);
      end
   endtask

   task automatic test_reentry();
      for (int k = 0; k < 2; k++) begin
         h0 = heal_count;
         playerState = AWAY;
         do_tick();
         playerState = CAMP;
         do_tick();
         tick_n(3);
         checks++;
         if (heal_count !== h0 + REENTRY_HEAL) begin
            failures++; $display("FAIL reentry_%0d got=%0d want=%0d", k, heal_count - h0, REENTRY_HEAL);
         end
      end
   endtask

   task automatic test_death_lit();
      campfireState = CAMP_MOVE;
      pulse_death();
      checks++;
      if (st[5:2] !== 4'b1110) begin
         failures++; $display("FAIL death_lit_enter got=%b want=%b", st[5:2], 4'b1110);
      end
      checks++;
      if (respawnState !== CAMP) begin
         failures++; $display("FAIL death_lit_pos got=%h want=%h", respawnState, CAMP);
      end
      tick_n(59);
      checks++;
      if (st[5:2] !== 4'b1110) begin
         failures++; $display("FAIL death_lit_hold got=%b want=%b", st[5:2], 4'b1110);
      end
      do_tick();
      checks++;
      if (st[5:2] !== 4'b1000) begin
         failures++; $display("FAIL death_lit_exit got=%b want=%b", st[5:2], 4'b1000);
      end
      campfireState = CAMP;
      h0 = heal_count;
      do_tick();
      checks++;
      if (st[2] !== 1'b1 || heal_count !== h0 + 1) begin
         failures++; $display("FAIL post_respawn_heal got=%b/%0d want=1/1", st[2], heal_count - h0);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge sim_clk);
      reset = 1'b0;
      #1;
      checks++;
      if (st !== 6'b000000 || respawnState !== DEF_SPAWN) begin
         failures++; $display("FAIL reset_mid got=%b/%h want=%b/%h", st, respawnState, 6'b000000, DEF_SPAWN);
      end
      @(negedge sim_clk);
      reset = 1'b1;
   endtask

   task automatic test_death_same_tick();
      playerState = CAMP;
      @(negedge sim_clk);
      frame_tick  = 1'b1;
      player_dead = 1'b1;
      @(negedge sim_clk);
      frame_tick  = 1'b0;
      player_dead = 1'b0;
      checks++;
      if (st !== 6'b011000 || respawnState !== DEF_SPAWN) begin
         failures++; $display("FAIL same_tick_enter got=%b/%h want=%b/%h", st, respawnState, 6'b011000, DEF_SPAWN);
      end
      tick_n(60);
      checks++;
      if (st !== 6'b000000) begin
         failures++; $display("FAIL same_tick_exit got=%b want=%b", st, 6'b000000);
      end
      do_tick();
      checks++;
      if (st !== 6'b110000) begin
         failures++; $display("FAIL same_tick_relight got=%b want=%b", st, 6'b110000);
      end
   endtask

   task automatic test_death_lighting();
      tick_n(5);
      pulse_death();
      checks++;
      if (st !== 6'b111000 || respawnState !== CAMP) begin
         failures++; $display("FAIL death_lighting_enter got=%b/%h want=%b/%h", st, respawnState, 6'b111000, CAMP);
      end
      playerState = FAR;
      h0 = heal_count;
      tick_n(60);
      checks++;
      if (st !== 6'b100000 || heal_count !== h0) begin
         failures++; $display("FAIL death_lighting_exit got=%b/%0d want=%b/0", st, heal_count - h0, 6'b100000);
      end
      playerState = CAMP;
      do_tick();
      checks++;
      if (heal_count !== h0 + 1) begin
         failures++; $display("FAIL death_lighting_touch got=%0d want=%0d", heal_count - h0, 1);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      heal_count    = 0;
      reset         = 1'b0;
      frame_tick    = 1'b0;
      player_dead   = 1'b0;
      campfireState = CAMP;
      playerState   = FAR;
      test_reset();
      test_death_unlit();
      test_overlap_boundary();
      test_lighting();
      test_reentry();
      test_death_lit();
      test_reset_mid();
      test_death_same_tick();
      test_death_lighting();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
